nios2_oci_dct_packer: RTL
=========================

# nios2_oci_dct_packer

Trace-side producer of the `dct_buffer`/`dct_count` pair inside the Nios II OCI debug-trace path. The block accepts one 2-bit branch-outcome code per cycle and shifts it into a 30-bit compression buffer (15 codes). It emits a 36-bit trace frame through a valid/ready handshake when the buffer fills or a flush is requested. Live buffer and count feed the OCI test bench; frames feed the trace FIFO.

## Interface
- No parameters. Widths are fixed: 15 codes × 2 bits, 36-bit frame.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `trc_enable` in 1: when low, `dct_valid` is ignored.
- `dct_valid` in 1: code present this cycle.
- `dct_code` in 2: 01 = conditional not taken, 10 = conditional taken, 11 = indirect/exception marker, 00 = ignored (treated as no code).
- `flush` in 1: single-cycle request to emit a partial buffer.
- `frame_ready` in 1: consumer accepts `frame_data` this cycle.
- `frame_valid` out 1: output frame register occupied.
- `frame_data` out 36: bit 35 = overflow since previous frame; bit 34 = flush frame; [33:30] = code count; [29:0] = buffer.
- `dct_buffer` out 30: live compression buffer.
- `dct_count` out 4: live code count, 0..15.
- `drop_count` out 8: saturating count of dropped codes.
- `trc_idle` out 1: `dct_count`==0 && !`frame_valid` && !flush pending.

## Operation
- Reset values: `dct_buffer`=0, `dct_count`=0, `frame_valid`=0, `frame_data`=0, `drop_count`=0, overflow flag=0, flush pending=0, `trc_idle`=1.
- Accept: acc = `trc_enable` && `dct_valid` && `dct_code`!=00.
- Shift: on accept, `dct_buffer` <= {`dct_code`, `dct_buffer`[29:2]} and `dct_count` += 1. The newest code is always in [29:28].
- Output free: `frame_free` = !`frame_valid` || `frame_ready`.
- Transfer: xfer = `frame_free` && (`dct_count`==15 || (flush pending && `dct_count`!=0)).
- On xfer:
  - `frame_data` <= {ovf, flush_frame, `dct_count`, `dct_buffer`}, where flush_frame = (`dct_count`!=15).
  - `frame_valid` <= 1.
  - Overflow flag cleared, flush pending cleared.
  - Buffer and count are cleared. If acc is high in the same cycle, the code lands in the fresh buffer instead: `dct_buffer`=={code,28'b0}, `dct_count`==1.
- Full stall: when `dct_count`==15 and there is no xfer, acc does not shift. The code is dropped, `drop_count` increments (saturating at 255) and the overflow flag is set.
- Frame handshake: `frame_ready` with `frame_valid` and no xfer gives `frame_valid` <= 0. `frame_data` stays stable while `frame_valid` && !`frame_ready`.
- Flush:
  - A `flush` pulse sets flush pending.
  - If `dct_count`==0 and no acc that cycle, pending clears next cycle and no frame is emitted.
  - A flush arriving with acc is applied after the shift, so the accepted code is included in the flushed frame.
  - Repeated `flush` while already pending has no extra effect.
- `trc_enable` low does not block xfer or flush. The buffered codes still drain.
- Reset mid-operation discards the buffer and any held frame immediately (asynchronous).

## Timing
- Accepted code is visible on `dct_buffer`/`dct_count` one cycle later.
- 15th code accepted at cycle N gives `dct_count`==15 at N+1 and `frame_valid`==1 at N+2 (output free). Meanwhile the buffer is cleared at N+2.
- Flush at cycle N with a non-empty buffer and free output gives `frame_valid` at N+2.
- Sustained codes with `frame_ready` tied high produce one frame every 15 accepted codes with zero drops.
- Back-to-back frames: a held frame released with `frame_ready` in the same cycle as xfer is replaced without a bubble.

## Test plan
- Reset, then 15 accepted codes 10 with `frame_ready`=1 -> `dct_count` steps 1..15. Frame 36'h_3_EAAAAAAA appears, i.e. {0,0,4'hF,30'h2AAAAAAA}. Count then returns to 0.
- Three codes 01 then `flush`, ready=1 -> frame {0,1,4'd3,30'h15000000}. `trc_idle` returns to 1.
- `flush` with an empty buffer -> no `frame_valid`. Flush pending clears after 1 cycle.
- `frame_ready`=0, 31 codes 10 -> first frame held stable and second buffer at 15. The 31st code is dropped and `drop_count`=1. After raising ready, the second frame has bit 35=1.
- `dct_count`==15, ready=1, same-cycle code 11 -> frame emitted, `dct_count`=1, `dct_buffer`=30'h30000000.
- `trc_enable`=0 or code 00 -> no change. Asserting `reset` mid-buffer (count 7, frame held) -> all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/nios2_oci_dct_packer.sv
// nios2_oci_dct_packer: packs 2-bit branch codes into a 30-bit buffer and
// emits 36-bit trace frames on fill or flush via a valid/ready handshake.
`default_nettype none

module nios2_oci_dct_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        trc_enable,
  input  logic        dct_valid,
  input  logic [1:0]  dct_code,
  input  logic        flush,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [35:0] frame_data,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic [7:0]  drop_count,
  output logic        trc_idle
);

  localparam logic [3:0] C_FULL = 4'd15;

  logic [29:0] dct_buffer_q, dct_buffer_d;
  logic [3:0]  dct_count_q,  dct_count_d;
  logic        frame_valid_q, frame_valid_d;
  logic [35:0] frame_data_q, frame_data_d;
  logic [7:0]  drop_count_q, drop_count_d;
  logic        ovf_q, ovf_d;
  logic        flush_pend_q, flush_pend_d;

  logic w_acc;
  logic w_full;
  logic w_free;
  logic w_xfer;

  assign w_acc  = trc_enable && dct_valid && (dct_code != 2'b00);
  assign w_full = (dct_count_q == C_FULL);
  assign w_free = !frame_valid_q || frame_ready;
  assign w_xfer = w_free && (w_full || (flush_pend_q && (dct_count_q != 4'd0)));

  always_comb begin
    dct_buffer_d  = dct_buffer_q;
    dct_count_d   = dct_count_q;
    frame_valid_d = frame_valid_q;
    frame_data_d  = frame_data_q;
    drop_count_d  = drop_count_q;
    ovf_d         = ovf_q;
    flush_pend_d  = flush_pend_q;

    if (w_xfer) begin
      frame_data_d  = {ovf_q, !w_full, dct_count_q, dct_buffer_q};
      frame_valid_d = 1'b1;
      ovf_d         = 1'b0;
      // A code arriving with the transfer starts the fresh buffer.
      if (w_acc) begin
        dct_buffer_d = {dct_code, 28'd0};
        dct_count_d  = 4'd1;
      end else begin
        dct_buffer_d = 30'd0;
        dct_count_d  = 4'd0;
      end
    end else begin
      if (frame_valid_q && frame_ready)
        frame_valid_d = 1'b0;
      if (w_acc) begin
        if (w_full) begin
          ovf_d = 1'b1;
          if (drop_count_q != 8'hFF)
            drop_count_d = drop_count_q + 8'd1;
        end else begin
          dct_buffer_d = {dct_code, dct_buffer_q[29:2]};
          dct_count_d  = dct_count_q + 4'd1;
        end
      end
    end

    // An empty buffer retires a pending flush without emitting a frame.
    if (flush_pend_q && (dct_count_q == 4'd0) && !w_acc)
      flush_pend_d = 1'b0;
    if (w_xfer)
      flush_pend_d = 1'b0;
    if (flush)
      flush_pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dct_buffer_q  <= 30'd0;
      dct_count_q   <= 4'd0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= 36'd0;
      drop_count_q  <= 8'd0;
      ovf_q         <= 1'b0;
      flush_pend_q  <= 1'b0;
    end else begin
      dct_buffer_q  <= dct_buffer_d;
      dct_count_q   <= dct_count_d;
      frame_valid_q <= frame_valid_d;
      frame_data_q  <= frame_data_d;
      drop_count_q  <= drop_count_d;
      ovf_q         <= ovf_d;
      flush_pend_q  <= flush_pend_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_data  = frame_data_q;
  assign dct_buffer  = dct_buffer_q;
  assign dct_count   = dct_count_q;
  assign drop_count  = drop_count_q;
  assign trc_idle    = (dct_count_q == 4'd0) && !frame_valid_q && !flush_pend_q;

endmodule

`default_nettype wire
